// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sched_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                The HDR state only exists when UART_TX_SCHED_HDR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    localparam int         MAX_REQ = 16;
    localparam logic [7:0] HDR_TAG = 8'hA0;

`ifdef UART_TX_SCHED_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } sched_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd2
    } sched_state_e;
`endif

    // Index width for a count of n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first asserted
//                request at or above the pointer, wrapping to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDW:0]       w_sum;

    // Rotate requests so the pointer position lands at bit 0, take the lowest set bit,
    // then map that offset back to an absolute requester index.
    always_comb begin
        w_rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
        w_sum   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && w_rot[i]) begin
                valid_o = 1'b1;
                w_sum   = {1'b0, ptr_i} + (IDW+1)'(i);
            end
        end
        if (w_sum >= (IDW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDW+1)'(NUM_REQ);
        end
        idx_o   = w_sum[IDW-1:0];
        grant_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter among NUM_REQ word producers.
//                Grants round-robin, latches the winner's word and streams it
//                LSB byte first over a valid/ready byte handshake.
//                Define UART_TX_SCHED_HDR_EN to prefix each word with the
//                header byte HDR_TAG | grant_id.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*WORD_BYTES*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [DATA_WIDTH-1:0]                    tx_data,
    output logic                                     tx_valid,
    input  logic                                     tx_ready,
    output logic                                     busy,
    output logic [id_width(NUM_REQ)-1:0]             grant_id
);

    localparam int             IDW       = id_width(NUM_REQ);
    localparam int             CW        = id_width(WORD_BYTES);
    localparam int             WORD_W    = WORD_BYTES * DATA_WIDTH;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  LAST_BYTE = CW'(WORD_BYTES - 1);

    sched_state_e       state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [IDW-1:0]     ptr_q,   ptr_d;
    logic [IDW-1:0]     gid_q,   gid_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_win;
    logic               w_any;
    logic [WORD_W-1:0]  w_sel_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_win),
        .valid_o (w_any)
    );

    // Select the granted requester's word slice.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_word = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // State register and datapath; reset drops any partially sent word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
        end
    end

    // Next-state logic: grant in IDLE, then advance one byte per transfer.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready = rstn ? w_grant : '0;
                    shreg_d   = w_sel_word;
                    gid_d     = w_win;
                    ptr_d     = (w_win == LAST_ID) ? '0 : w_win + 1'b1;
                    cnt_d     = '0;
`ifdef UART_TX_SCHED_HDR_EN
                    state_d   = ST_HDR;
`else
                    state_d   = ST_SEND;
`endif
                end
            end
`ifdef UART_TX_SCHED_HDR_EN
            ST_HDR: begin
                if (tx_ready) begin
                    state_d = ST_SEND;
                end
            end
`endif
            ST_SEND: begin
                if (tx_ready) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = shreg_q >> DATA_WIDTH;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte presented to the transmitter; held stable by the registered state.
    always_comb begin
        tx_data = '0;
        case (state_q)
            ST_SEND: tx_data = shreg_q[DATA_WIDTH-1:0];
`ifdef UART_TX_SCHED_HDR_EN
            ST_HDR:  tx_data = DATA_WIDTH'(HDR_TAG | {4'h0, 4'(gid_q)});
`endif
            default: tx_data = '0;
        endcase
    end

    assign tx_valid = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler (4 x 32-bit words).
//                Honours UART_TX_SCHED_HDR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int WB = 4;
`ifdef UART_TX_SCHED_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic         clk       = 1'b0;
    logic         rstn      = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data  = '0;
    logic [3:0]   req_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready  = 1'b1;
    logic         busy;
    logic [1:0]   grant_id;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .WORD_BYTES (WB)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_bytes[$];
    int         exp_gid[$];
    int         remaining[4];
    int         seq[4];
    logic       bp_mode    = 1'b0;
    int         bp_cnt     = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    int         pend_gid   = -1;
    logic       s_busy     = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] word;
        logic [31:0] send_order;   // expected bytes, first-sent in the MSB
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mkword(input int i, input int n);
        return 32'h0100_0000 * (i + 1) + 32'h0001_0000 * (n + 1) + 32'h0000_A500 + 32'(i * 16 + n);
    endfunction

    task automatic push_word(input int id, input logic [31:0] w);
        exp_gid.push_back(id);
        if (HDR != 0) exp_bytes.push_back(8'hA0 | 8'(id));
        for (int b = 0; b < WB; b++) exp_bytes.push_back(w[8*b +: 8]);
    endtask

    // One clock: monitor at the falling edge, drive requesters/ready after the rising edge.
    task automatic tick();
        logic [3:0] acc;
        logic       xfer;
        int         g;
        @(negedge clk);
        xfer   = tx_valid && tx_ready;
        s_busy = busy;
        if (pend_gid >= 0) begin
            check("grant_id", 32'(grant_id), pend_gid);
            pend_gid = -1;
        end
        if (rstn && prev_stall) begin
            check("stall_valid", 32'(tx_valid), 1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (xfer) begin
            if (exp_bytes.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
            end
        end
        acc = req_ready;
        if (acc != 4'b0) begin
            if (exp_gid.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_grant actual=%0h required=none", acc);
            end else begin
                g = exp_gid.pop_front();
                check("grant_onehot", 32'(acc), 32'(1) << g);
                pend_gid = g;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (remaining[i] > 0) begin
                    remaining[i]--;
                    seq[i]++;
                    req_data[i*32 +: 32] = mkword(i, seq[i]);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (bp_mode) begin
            if (xfer) bp_cnt = 0;
            else if (bp_cnt < 5) bp_cnt++;
            tx_ready = (bp_cnt == 5);
        end
    endtask

    task automatic run_quiet(input int max, output int n);
        logic quiet;
        n = 0;
        quiet = 1'b0;
        while (!quiet && n < max) begin
            tick();
            n++;
            quiet = (exp_bytes.size() == 0) && (exp_gid.size() == 0) && !s_busy;
        end
        if (!quiet) begin
            n_checks++; n_fail++;
            $display("FAIL timeout actual=%0d_cycles required=quiet", n);
        end
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        req_valid  = '0;
        exp_bytes.delete();
        exp_gid.delete();
        pend_gid   = -1;
        prev_stall = 1'b0;
        bp_mode    = 1'b0;
        tx_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin remaining[i] = 0; seq[i] = 0; end
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        vecs[0] = '{id: 2, word: 32'h1122_3344, send_order: 32'h4433_2211};
        vecs[1] = '{id: 0, word: 32'hA5A5_0F0F, send_order: 32'h0F0F_A5A5};
        vecs[2] = '{id: 3, word: 32'hFFFF_0000, send_order: 32'h0000_FFFF};
        vecs[3] = '{id: 1, word: 32'hDEAD_BEEF, send_order: 32'hEFBE_ADDE};
        for (int i = 0; i < 4; i++) begin remaining[i] = 0; seq[i] = 0; end

        // Reset state with every requester asserting.
        req_valid = 4'hF;
        req_data  = {4{32'h1234_5678}};
        #3;
        check("reset_tx_valid", 32'(tx_valid), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        tick();
        req_valid = '0;
        rstn = 1'b1;
        tick();

        // Single-request vectors.
        for (int v = 0; v < 4; v++) begin
            req_data[vecs[v].id*32 +: 32] = vecs[v].word;
            req_valid[vecs[v].id] = 1'b1;
            exp_gid.push_back(vecs[v].id);
            if (HDR != 0) exp_bytes.push_back(8'hA0 | 8'(vecs[v].id));
            for (int b = 0; b < WB; b++) exp_bytes.push_back(vecs[v].send_order[31-8*b -: 8]);
            run_quiet(50, n);
            check("vec_cycles", n, WB + 2 + HDR);
            check("vec_grant_id", 32'(grant_id), vecs[v].id);
            check("vec_busy_done", 32'(busy), 0);
        end

        // All four simultaneous after reset: 0,1,2,3 with one idle cycle between words.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = mkword(i, 0);
            push_word(i, mkword(i, 0));
        end
        req_valid = 4'hF;
        run_quiet(200, n);
        check("all4_cycles", n, 4 * (WB + 1 + HDR) + 1);

        // Backpressure: five not-ready cycles before every byte.
        bp_mode  = 1'b1;
        bp_cnt   = 0;
        tx_ready = 1'b0;
        req_data[32 +: 32] = 32'h8877_6655;
        push_word(1, 32'h8877_6655);
        req_valid[1] = 1'b1;
        run_quiet(300, n);
        check("bp_cycles", n, 6 * (WB + HDR) + 1);
        bp_mode  = 1'b0;
        tx_ready = 1'b1;

        // Fairness: requesters 0 and 3 both held for three words each.
        do_reset();
        req_data[0 +: 32]  = mkword(0, 0);
        req_data[96 +: 32] = mkword(3, 0);
        remaining[0] = 2;
        remaining[3] = 2;
        for (int k = 0; k < 3; k++) begin
            push_word(0, mkword(0, k));
            push_word(3, mkword(3, k));
        end
        req_valid = 4'b1001;
        run_quiet(300, n);
        check("fair_cycles", n, 6 * (WB + 1 + HDR) + 1);
        check("fair_valid_dropped", 32'(req_valid), 0);

        // Asynchronous reset after the second byte of a word.
        do_reset();
        req_data[64 +: 32] = mkword(2, 7);
        push_word(2, mkword(2, 7));
        req_valid[2] = 1'b1;
        tick();
        tick();
        tick();
        check("mid_bytes_left", exp_bytes.size(), WB + HDR - 2);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        exp_bytes.delete();
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        req_data[32 +: 32] = mkword(1, 0);
        req_data[96 +: 32] = mkword(3, 0);
        push_word(1, mkword(1, 0));
        push_word(3, mkword(3, 0));
        req_valid = 4'b1010;
        run_quiet(200, n);
        check("post_rst_cycles", n, 2 * (WB + 1 + HDR) + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler sharing one UART transmitter among NUM_REQ word-wide requesters (e.g. RSA result/debug producers). Grants one requester at a time, latches its WORD_BYTES-byte word, and feeds it byte by byte, LSB byte first, to the transmitter over its valid/ready byte handshake. Sits between the CPU-side producers and the single `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16.
- `DATA_WIDTH`, 8: byte width; must match the transmitter.
- `WORD_BYTES`, 4: bytes per requester word, ≥1.
- `clk` in 1: single clock, all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester word valid.
- `req_data` in NUM_REQ*WORD_BYTES*DATA_WIDTH: requester i word at slice i.
- `req_ready` out NUM_REQ: one-hot word accept.
- `tx_data` out DATA_WIDTH: byte to transmitter.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: transmitter ready; transfer = `tx_valid & tx_ready` at an edge.
- `busy` out 1: word in flight.
- `grant_id` out $clog2(NUM_REQ) (min 1): index of last granted requester.

## Operation
- States: IDLE, HDR (only with header feature), SEND.
- IDLE: if any `req_valid`, winner = first set bit searching upward from pointer `ptr`, wrapping. `req_ready[winner]` = 1 combinationally, all others 0. At the edge: latch winner's word into shift register, `grant_id`←winner, `ptr`←(winner+1) mod NUM_REQ, `busy`←1, byte counter←0, go to HDR (feature on) or SEND.
- HDR: drive header byte, `tx_valid`=1; on transfer go to SEND.
- SEND: `tx_data` = shift register low byte, `tx_valid`=1. On transfer: if counter = WORD_BYTES-1 go to IDLE, clear `tx_valid`, `busy`; else shift right one byte, counter+1, `tx_valid` stays 1.
- `tx_valid` never drops and `tx_data` never changes without a transfer.
- Requesters hold `req_valid`/data until `req_ready`; dropping `req_valid` while not granted is legal and has no effect.
- NUM_REQ=1: always grants 0. WORD_BYTES=1: single-byte SEND.

## Timing
- Reset (rstn low, async): state IDLE, `tx_valid` 0, `tx_data` 0, `busy` 0, `grant_id` 0, `ptr` 0, `req_ready` forced 0 while rstn low.
- Reset mid-word: partial word discarded; no resume.
- Grant latency: `req_valid` seen in IDLE at cycle t → accept at edge ending t → `tx_valid` high from cycle t+1.
- With `tx_ready` held 1: one byte per cycle; word of WORD_BYTES bytes occupies WORD_BYTES (+1 header) cycles after grant.
- Return to IDLE costs one cycle; back-to-back words have one cycle with `tx_valid` 0.
- Simultaneous requests: served in rotating order from `ptr`; no requester waits more than NUM_REQ-1 words.
- Transmitter deasserts `tx_ready` the cycle after a transfer; the scheduler holds the next byte until `tx_ready` returns.

## Configuration
- `UART_TX_SCHED_HDR_EN` defined: each word is preceded by header byte `HDR_TAG | grant_id` (HDR_TAG = 8'hA0, id in low nibble); frame = 1+WORD_BYTES bytes.
- Undefined: HDR state and header logic absent; frame = WORD_BYTES bytes.

## Structure
- Package `uart_sched_pkg`: state enum, `HDR_TAG` constant, `MAX_REQ` = 16.
- Sub-module `rr_arbiter`: combinational round-robin winner/one-hot from request vector and pointer, parameterised by NUM_REQ.
- Top holds FSM, shift register, byte counter, pointer.

## Test plan
- Single request: req 2 valid, data 32'h11223344, `tx_ready`=1 → `req_ready[2]` one cycle, bytes 44,33,22,11 on consecutive cycles, `grant_id`=2, `busy` then 0.
- All four valid, distinct words, after reset → grants 0,1,2,3 in order, each word complete before next, one idle cycle between.
- Backpressure: `tx_ready` low 5 cycles per byte → `tx_valid`/`tx_data` stable throughout, each byte sent exactly once.
- Fairness: req 0 held valid continuously, req 3 valid → order 0,3,0,3…, req 3 never starved.
- Async reset asserted after second byte → outputs reset immediately, remaining bytes never sent; next request restarts from `ptr`=0.
- With `UART_TX_SCHED_HDR_EN`: req 1, data 32'hDEADBEEF → A1,EF,BE,AD,DE.
